sram_1p_ctrl: RTL



---
 rtl/sram_ctrl_pkg.sv | 14 +
 rtl/sram_byte_merge.sv | 21 ++
 rtl/sram_1p_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared constants and FSM encoding for the single-port SRAM controller
package sram_ctrl_pkg;

  localparam int SRAM_DEPTH = 816;
  localparam int SRAM_AW    = 10;
  localparam int SRAM_DW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RMW  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_byte_merge.sv
// rtl/sram_byte_merge.sv - per-byte select between new and old data words
module sram_byte_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   new_data,
  input  logic [DW-1:0]   old_data,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   merged
);

  // Each enabled byte lane takes the new data, the rest keep the old word
  always_comb begin
    merged = old_data;
    for (int i = 0; i < DW/8; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sram_1p_ctrl.sv
// rtl/sram_1p_ctrl.sv - request/response controller for the 816x32 single-port SRAM macro
module sram_1p_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = SRAM_DEPTH,
  parameter int AW    = SRAM_AW,
  parameter int DW    = SRAM_DW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [DW-1:0]   rsp_rdata,
  output logic            sram_ceb,
  output logic            sram_web,
  output logic [AW-1:0]   sram_a,
  output logic [DW-1:0]   sram_d,
  input  logic [DW-1:0]   sram_q
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_rd_q, rsp_rd_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic [AW-1:0]     lat_addr_q, lat_addr_d;
  logic [DW-1:0]     lat_wdata_q, lat_wdata_d;
  logic [DW/8-1:0]   lat_be_q, lat_be_d;
  logic [DW-1:0]     merged;
  logic              in_range;
  logic              be_full;
  logic              be_none;

  assign in_range = ({1'b0, req_addr} < DEPTH_W);
  assign be_full  = &req_be;
  assign be_none  = ~|req_be;

  sram_byte_merge #(.DW(DW)) u_merge (
    .new_data (lat_wdata_q),
    .old_data (sram_q),
    .be       (lat_be_q),
    .merged   (merged)
  );

  // Read responses pass the macro's registered Q straight through; otherwise hold the last value
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_valid_q ? (rsp_rd_q ? sram_q : '0) : hold_q;

  // FSM next state, macro strobes and response scheduling
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rd_d    = 1'b0;
    hold_d      = rsp_rdata;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    req_ready   = 1'b0;
    sram_ceb    = 1'b1;
    sram_web    = 1'b1;
    sram_a      = '0;
    sram_d      = '0;
    if (!RST) begin
      case (state_q)
        IDLE, RD: begin
          req_ready = 1'b1;
          state_d   = IDLE;
          if (req_valid) begin
            if (!in_range) begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end else if (!req_we) begin
              sram_ceb    = 1'b0;
              sram_a      = req_addr;
              state_d     = RD;
              rsp_valid_d = 1'b1;
              rsp_rd_d    = 1'b1;
            end else if (be_full) begin
              sram_ceb    = 1'b0;
              sram_web    = 1'b0;
              sram_a      = req_addr;
              sram_d      = req_wdata;
              rsp_valid_d = 1'b1;
            end else if (be_none) begin
              rsp_valid_d = 1'b1;
            end else begin
              // Partial write: fetch the old word now, merge and write it back next cycle
              sram_ceb    = 1'b0;
              sram_a      = req_addr;
              lat_addr_d  = req_addr;
              lat_wdata_d = req_wdata;
              lat_be_d    = req_be;
              state_d     = RMW;
            end
          end
        end
        RMW: begin
          sram_ceb    = 1'b0;
          sram_web    = 1'b0;
          sram_a      = lat_addr_q;
          sram_d      = merged;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, request latch and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
      hold_q      <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
      hold_q      <= hold_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
    end
  end

endmodule
